// File: rtl/key_evt_pkg.sv
// Shared constants and the round-robin pick helper for the key event scheduler.
package key_evt_pkg;

  localparam int NUM_KEYS   = 9;
  localparam int KEY_CODE_W = 4;

  localparam logic [KEY_CODE_W-1:0] KEY_0 = 4'd0;
  localparam logic [KEY_CODE_W-1:0] KEY_1 = 4'd1;
  localparam logic [KEY_CODE_W-1:0] KEY_2 = 4'd2;
  localparam logic [KEY_CODE_W-1:0] KEY_3 = 4'd3;
  localparam logic [KEY_CODE_W-1:0] KEY_4 = 4'd4;
  localparam logic [KEY_CODE_W-1:0] KEY_5 = 4'd5;
  localparam logic [KEY_CODE_W-1:0] KEY_6 = 4'd6;
  localparam logic [KEY_CODE_W-1:0] KEY_7 = 4'd7;
  localparam logic [KEY_CODE_W-1:0] KEY_8 = 4'd8;

  typedef struct packed {
    logic                  found;
    logic [KEY_CODE_W-1:0] index;
  } pick_t;

  // First set bit of pend at or above ptr, wrapping from key 8 back to key 0.
  function automatic pick_t rr_pick(input logic [NUM_KEYS-1:0] pend,
                                    input logic [KEY_CODE_W-1:0] ptr);
    pick_t      res;
    logic [4:0] idx;
    res.found = 1'b0;
    res.index = 4'd0;
    for (int j = 0; j < NUM_KEYS; j++) begin
      idx = 5'(ptr) + 5'(j);
      if (idx >= 5'(NUM_KEYS)) begin
        idx = idx - 5'(NUM_KEYS);
      end else begin
        idx = idx;
      end
      if (!res.found && pend[idx[3:0]]) begin
        res.found = 1'b1;
        res.index = idx[3:0];
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// First-word fall-through FIFO holding queued key codes; rdata is valid while level is non-zero.
module key_evt_fifo
  import key_evt_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = KEY_CODE_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LW-1:0]    level_r;

  // Pointer and occupancy bookkeeping; pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (push) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (pop)  rd_ptr_r <= rd_ptr_r + 1'b1;
      level_r <= level_r + LW'(push) - LW'(pop);
    end
  end

  // Storage needs no reset: entries are only read once counted in level.
  always_ff @(posedge clk) begin
    if (push) mem_r[wr_ptr_r] <= wdata;
  end

  assign rdata = mem_r[rd_ptr_r];
  assign level = level_r;

endmodule

// File: rtl/key_event_scheduler.sv
// Latches key press pulses, arbitrates them round-robin into a FIFO and presents them over valid/ready.
module key_event_scheduler
  import key_evt_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                  CLOCK_50,
  input  logic                  RST_N,
  input  logic [NUM_KEYS-1:0]   key_pulse,
  output logic                  ev_valid,
  output logic [KEY_CODE_W-1:0] ev_code,
  input  logic                  ev_ready,
  output logic                  merged,
  input  logic                  merged_clr,
  output logic [4:0]            level,
  output logic [KEY_CODE_W-1:0] last_code
);

  localparam int LW = $clog2(DEPTH) + 1;

  logic [NUM_KEYS-1:0]   pend_r;
  logic [KEY_CODE_W-1:0] rr_ptr_r;
  logic                  merged_r;
  logic [KEY_CODE_W-1:0] last_code_r;

  logic [LW-1:0]         fifo_level_s;
  logic [KEY_CODE_W-1:0] head_s;
  pick_t                 pick_s;
  logic                  pop_s;
  logic                  push_ok_s;
  logic                  grant_s;
  logic [NUM_KEYS-1:0]   grant_vec_s;
  logic                  merge_s;

  // Arbitration on registered pend; a full FIFO still accepts a push when it pops.
  always_comb begin
    pick_s      = rr_pick(pend_r, rr_ptr_r);
    pop_s       = ev_valid & ev_ready;
    push_ok_s   = (fifo_level_s < LW'(DEPTH)) | pop_s;
    grant_s     = pick_s.found & push_ok_s;
    grant_vec_s = 9'd0;
    if (grant_s) begin
      grant_vec_s = 9'd1 << pick_s.index;
    end else begin
      grant_vec_s = 9'd0;
    end
    merge_s = |(key_pulse & pend_r & ~grant_vec_s);
  end

  // Pending latches, round-robin pointer, sticky merge flag and last popped code.
  always_ff @(posedge CLOCK_50) begin
    if (!RST_N) begin
      pend_r      <= 9'd0;
      rr_ptr_r    <= 4'd0;
      merged_r    <= 1'b0;
      last_code_r <= 4'd0;
    end else begin
      pend_r <= (pend_r & ~grant_vec_s) | key_pulse;
      if (grant_s) begin
        rr_ptr_r <= (pick_s.index == KEY_8) ? KEY_0 : pick_s.index + 4'd1;
      end
      if (merge_s) begin
        merged_r <= 1'b1;
      end else if (merged_clr) begin
        merged_r <= 1'b0;
      end
      if (pop_s) begin
        last_code_r <= ev_code;
      end
    end
  end

  key_evt_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (KEY_CODE_W)
  ) u_fifo (
    .clk   (CLOCK_50),
    .rst_n (RST_N),
    .push  (grant_s),
    .wdata (pick_s.index),
    .pop   (pop_s),
    .rdata (head_s),
    .level (fifo_level_s)
  );

  assign ev_valid  = (fifo_level_s != '0);
  assign ev_code   = ev_valid ? head_s : 4'd0;
  assign level     = 5'(fifo_level_s);
  assign merged    = merged_r;
  assign last_code = last_code_r;

endmodule

// File: tb/tb_key_event_scheduler.sv
// Self-checking bench: fixed vectors, directed multi-cycle sequences and random traffic against a queue model.
module tb_key_event_scheduler;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [8:0] key_pulse = 9'd0;
  logic       ev_ready = 1'b0;
  logic       merged_clr = 1'b0;
  logic       ev_valid;
  logic [3:0] ev_code;
  logic       merged;
  logic [4:0] level;
  logic [3:0] last_code;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  bit m_pend [9];
  int m_rr;
  int q[$];
  bit m_merged;
  int m_last;

  key_event_scheduler #(.DEPTH(DEPTH)) dut (
    .CLOCK_50   (clk),
    .RST_N      (rst_n),
    .key_pulse  (key_pulse),
    .ev_valid   (ev_valid),
    .ev_code    (ev_code),
    .ev_ready   (ev_ready),
    .merged     (merged),
    .merged_clr (merged_clr),
    .level      (level),
    .last_code  (last_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [8:0] pulse;
    logic       rdy;
    logic       clr;
    int         valid;
    int         code;
    int         lvl;
    int         mrg;
    int         last;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input logic r, input logic [8:0] p, input logic rd, input logic c);
    int g;
    bit pop, ok, mg;
    if (!r) begin
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_rr = 0;
      q.delete();
      m_merged = 1'b0;
      m_last = 0;
      return;
    end
    pop = (q.size() != 0) && rd;
    ok  = (q.size() < DEPTH) || pop;
    g   = -1;
    if (ok) begin
      for (int j = 0; j < 9; j++) begin
        if (g < 0 && m_pend[(m_rr + j) % 9]) g = (m_rr + j) % 9;
      end
    end
    mg = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (p[i] && m_pend[i] && i != g) mg = 1'b1;
    end
    if (pop) m_last = q.pop_front();
    if (g >= 0) begin
      q.push_back(g);
      m_rr = (g + 1) % 9;
    end
    for (int i = 0; i < 9; i++) begin
      m_pend[i] = (m_pend[i] && i != g) || p[i];
    end
    if (mg) m_merged = 1'b1;
    else if (c) m_merged = 1'b0;
  endtask

  task automatic step(input logic r, input logic [8:0] p, input logic rd, input logic c);
    rst_n      = r;
    key_pulse  = p;
    ev_ready   = rd;
    merged_clr = c;
    @(posedge clk);
    model_update(r, p, rd, c);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".valid"}, int'(ev_valid), (q.size() != 0) ? 1 : 0);
    chk({tag, ".code"}, int'(ev_code), (q.size() != 0) ? q[0] : 0);
    chk({tag, ".level"}, int'(level), q.size());
    chk({tag, ".merged"}, int'(merged), int'(m_merged));
    chk({tag, ".last"}, int'(last_code), m_last);
  endtask

  initial begin
    // rst, pulse, rdy, clr | valid, code, level, merged, last
    tbl[0] = '{1'b0, 9'h000, 1'b1, 1'b0, 0, 0, 0, 0, 0};
    tbl[1] = '{1'b1, 9'h010, 1'b1, 1'b0, 0, 0, 0, 0, 0};
    tbl[2] = '{1'b1, 9'h000, 1'b1, 1'b0, 1, 4, 1, 0, 0};
    tbl[3] = '{1'b1, 9'h000, 1'b1, 1'b0, 0, 0, 0, 0, 4};
    tbl[4] = '{1'b1, 9'h009, 1'b0, 1'b0, 0, 0, 0, 0, 4};
    tbl[5] = '{1'b1, 9'h008, 1'b0, 1'b0, 1, 0, 1, 1, 4};
    tbl[6] = '{1'b1, 9'h000, 1'b0, 1'b1, 1, 0, 2, 0, 4};
    tbl[7] = '{1'b1, 9'h000, 1'b1, 1'b0, 1, 3, 1, 0, 0};
    tbl[8] = '{1'b1, 9'h000, 1'b1, 1'b0, 0, 0, 0, 0, 3};

    #2;
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].rst, tbl[i].pulse, tbl[i].rdy, tbl[i].clr);
      chk($sformatf("vec%0d.valid", i), int'(ev_valid), tbl[i].valid);
      chk($sformatf("vec%0d.code", i), int'(ev_code), tbl[i].code);
      chk($sformatf("vec%0d.level", i), int'(level), tbl[i].lvl);
      chk($sformatf("vec%0d.merged", i), int'(merged), tbl[i].mrg);
      chk($sformatf("vec%0d.last", i), int'(last_code), tbl[i].last);
    end

    // All nine keys at once, consumer stalled, then drained in order.
    step(1'b0, 9'h000, 1'b0, 1'b0);
    step(1'b1, 9'h1FF, 1'b0, 1'b0);
    for (int n = 1; n <= 8; n++) begin
      step(1'b1, 9'h000, 1'b0, 1'b0);
      chk("burst.fill_level", int'(level), n);
    end
    step(1'b1, 9'h000, 1'b0, 1'b0);
    chk("burst.stall_level", int'(level), 8);
    for (int n = 0; n < 9; n++) begin
      chk("burst.valid", int'(ev_valid), 1);
      chk("burst.code", int'(ev_code), n);
      step(1'b1, 9'h000, 1'b1, 1'b0);
      if (n == 0) chk("burst.full_push_pop_level", int'(level), 8);
      chk_model("burst");
    end
    chk("burst.drained", int'(level), 0);
    chk("burst.merged", int'(merged), 0);

    // Round-robin fairness: 5 first, then {2,7} gives 7,2; then {0,4} from ptr 3 gives 4,0.
    step(1'b0, 9'h000, 1'b0, 1'b0);
    step(1'b1, 9'h020, 1'b0, 1'b0);
    step(1'b1, 9'h000, 1'b0, 1'b0);
    step(1'b1, 9'h084, 1'b0, 1'b0);
    step(1'b1, 9'h000, 1'b0, 1'b0);
    step(1'b1, 9'h000, 1'b0, 1'b0);
    step(1'b1, 9'h011, 1'b0, 1'b0);
    step(1'b1, 9'h000, 1'b0, 1'b0);
    step(1'b1, 9'h000, 1'b0, 1'b0);
    chk("rr.level", int'(level), 5);
    begin
      int exp_order [5] = '{5, 7, 2, 4, 0};
      for (int n = 0; n < 5; n++) begin
        chk("rr.code", int'(ev_code), exp_order[n]);
        step(1'b1, 9'h000, 1'b1, 1'b0);
      end
    end
    chk_model("rr");

    // Reset in the middle of traffic: level 5 with keys 5,6,7 still pending.
    step(1'b0, 9'h000, 1'b0, 1'b0);
    step(1'b1, 9'h0FF, 1'b0, 1'b0);
    for (int n = 0; n < 5; n++) step(1'b1, 9'h000, 1'b0, 1'b0);
    chk("midrst.level_before", int'(level), 5);
    step(1'b0, 9'h000, 1'b1, 1'b0);
    chk("midrst.valid", int'(ev_valid), 0);
    chk("midrst.level", int'(level), 0);
    chk("midrst.last", int'(last_code), 0);
    for (int n = 0; n < 4; n++) begin
      step(1'b1, 9'h000, 1'b1, 1'b0);
      chk("midrst.no_stale", int'(ev_valid), 0);
    end
    chk_model("midrst");

    // Random traffic against the model, alternating consumer-heavy and stall-heavy phases.
    for (int i = 0; i < 3000; i++) begin
      logic [8:0] p;
      logic       rd, r, c;
      for (int b = 0; b < 9; b++) p[b] = ($urandom_range(0, 5) == 0);
      if (((i / 300) % 2) == 0) rd = ($urandom_range(0, 3) != 0);
      else                      rd = ($urandom_range(0, 5) == 0);
      r = ($urandom_range(0, 399) != 0);
      c = ($urandom_range(0, 15) == 0);
      step(r, p, rd, c);
      chk_model("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/key_event_scheduler.md
# key_event_scheduler

Turns the one-cycle key pulses from the 3x3 key matrix scanner (`flagKey3x3[8:0]`) into an ordered stream of 4-bit key codes for the network test controller. Each key has a pending latch, so a press is never lost while the consumer is busy. A round-robin arbiter picks one pending key per cycle and pushes its code into a small FIFO. The output is a valid/ready handshake; a sticky flag reports presses that had to be merged.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, 2..16.
- `CLOCK_50`  in  1  system clock; all logic on the rising edge.
- `RST_N`  in  1  reset; synchronous, active-low.
- `key_pulse`  in  9  one-cycle press pulses, bit i = key i (row*3+col); several bits may be high in the same cycle.
- `ev_valid`  out  1  head event available.
- `ev_code`  out  4  key index 0..8 of the head event; 0 when `ev_valid`=0.
- `ev_ready`  in  1  consumer accepts the head event.
- `merged`  out  1  sticky; a press arrived while the same key was already pending.
- `merged_clr`  in  1  clears `merged`.
- `level`  out  5  current FIFO occupancy, 0..DEPTH.
- `last_code`  out  4  code of the most recently popped event, for LED display.

## Operation
- Reset (RST_N=0 at an edge) sets: pend=0, rr_ptr=0, FIFO empty, `level`=0, `ev_valid`=0, `ev_code`=0, `merged`=0, `last_code`=0. A reset mid-operation discards all pending and queued events.
- Pending latch, per key i, each cycle:
  - Set pend[i] when key_pulse[i]=1.
  - Clear pend[i] when key i is granted, except when key_pulse[i]=1 in that same cycle; then pend[i] stays set as a new event.
  - key_pulse[i]=1 while pend[i]=1 and not granted that cycle: the press is merged and `merged` is set.
- Arbiter (combinational on the registered pend):
  - Search from rr_ptr upward, wrapping 8->0; the first set bit is grant k.
  - Grant happens only if pend≠0 and push_ok.
  - On grant: write code k to the FIFO and set rr_ptr = (k==8) ? 0 : k+1.
  - With no grant, rr_ptr holds.
- FIFO (first-word fall-through):
  - pop = ev_valid & ev_ready.
  - push_ok = (level<DEPTH) | pop, so a push is allowed into a full FIFO in the same cycle as a pop.
  - level ← level + push − pop.
  - Simultaneous push and pop on an empty FIFO cannot occur, since ev_valid=0.
- Output:
  - ev_valid = (level≠0); ev_code = head entry, else 0.
  - ev_ready while ev_valid=0 is ignored.
  - On pop, last_code ← popped code.
- Merged flag:
  - `merged_clr`=1 clears `merged`.
  - If `merged_clr` and a new merge happen in the same cycle, the set wins.
- Arithmetic:
  - FIFO read/write pointers are log2(DEPTH) bits and wrap naturally.
  - rr_ptr is 4 bits; values 9..15 never occur.

## Timing
- key_pulse[i] high in cycle t → pend[i]=1 after edge t → ev_valid=1 after edge t+1, provided the FIFO is empty and no other key is pending. Minimum latency is 2 cycles.
- Throughput: one push and one pop per cycle. N simultaneous presses drain into the FIFO over N cycles.
- Outputs are registered or decoded from registers only; there is no combinational path from ev_ready to ev_valid or ev_code.
- When the FIFO is full and no pop occurs, grants stall; pend holds the keys and rr_ptr does not advance.

## Structure
- Package `key_evt_pkg` holds:
  - NUM_KEYS=9 and KEY_CODE_W=4.
  - Key code constants KEY_0..KEY_8.
  - A function rr_pick(pend, ptr) returning {found, index}.
- Sub-module `key_evt_fifo` (parameterised DEPTH, WIDTH):
  - Ports: push, wdata, pop, rdata, level.
  - Same clock and synchronous active-low reset as the parent.
- The top level holds the pending latches, the arbiter, rr_ptr, `merged` and `last_code`.

## Test plan
- Single press, ev_ready=1: key_pulse=9'h010 for 1 cycle → ev_valid high exactly 2 edges later with ev_code=4 for 1 cycle; then last_code=4 and level=0.
- Simultaneous presses, ev_ready=0: key_pulse=9'h1FF for 1 cycle → level climbs 1..8 over 8 cycles and key 8 stays pending. Then ev_ready=1 → codes 0,1,2,…,8 in order, no gaps, merged=0.
- Round-robin fairness: grant key 5 first, then pend={2,7} → order is 7 then 2; rr_ptr=3 afterwards.
- Merge: key 3 pulse, FIFO held full with ev_ready=0, second key 3 pulse → merged=1 and only one code 3 is eventually delivered. merged_clr=1 → merged=0 next cycle.
- Full FIFO with push and pop in the same cycle: level=8, ev_ready=1, key 6 pending → level stays 8 and code 6 is enqueued that cycle.
- Reset mid-operation: level=5 with 3 keys pending, RST_N=0 for 1 edge → all outputs at reset values after that edge, and no stale events afterwards.
